servo_pwm_driver: RTL

- Output-side counterpart to the switch-input conditioning logic: turns an internal, synchronous position command into a clean, glitch-free, fixed-period servo pulse train on an FPGA pin.
- One instance per plate-tilt axis in the ball-and-plate controller; fed by the control loop through a valid/ready handshake.
- New positions take effect only at frame boundaries, so pulses are never runt or stretched.

---
 rtl/servo_pkg.sv | 30 +++
 rtl/servo_pwm_driver_if.sv | 28 ++
 rtl/servo_frame_timer.sv | 38 +++
 rtl/servo_pwm_driver.sv | 137 +++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Purpose : shared constants, default 65 MHz timing and the position-to-width helper for the servo driver.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   POS_W, CENTER_POS        - command width and mid-travel position
//   DEF_*                    - default timing for a 65 MHz core clock (20 ms frame, 1.0..2.0 ms pulse)
//   pos_to_width()           - MIN_PULSE + pos*STEP, 32-bit unsigned; callers truncate to their counter width
package servo_pkg;

    localparam int unsigned POS_W      = 8;
    localparam int unsigned CENTER_POS = 128;

    localparam int unsigned DEF_FRAME_CYCLES = 1300000;
    localparam int unsigned DEF_MIN_PULSE    = 65000;
    localparam int unsigned DEF_STEP         = 255;
    localparam int unsigned DEF_COUNT_W      = 21;
    localparam int unsigned DEF_MAX_SLEW     = 2550;

    // Pure unsigned arithmetic, no saturation. Truncating the 32-bit result
    // to the counter width gives the same value as doing the sum in that width.
    function automatic logic [31:0] pos_to_width(
        input logic [POS_W-1:0] pos,
        input int unsigned      min_pulse,
        input int unsigned      step
    );
        return min_pulse + ({{(32-POS_W){1'b0}}, pos} * step);
    endfunction

endpackage

// File: rtl/servo_pwm_driver_if.sv
// Purpose : position command channel from the control loop into one servo axis.
// Latency : n/a (wires only).
// Backpressure: valid/ready; the sender holds pos and pos_valid until pos_ready is seen high.
//
// Signals:
//   pos        master->slave  commanded position 0..255
//   pos_valid  master->slave  pos is valid this cycle
//   pos_ready  slave->master  driver has an empty pending slot
interface servo_pwm_driver_if;
    import servo_pkg::*;

    logic [POS_W-1:0] pos;
    logic             pos_valid;
    logic             pos_ready;

    modport master (
        output pos,
        output pos_valid,
        input  pos_ready
    );

    modport slave (
        input  pos,
        input  pos_valid,
        output pos_ready
    );

endinterface

// File: rtl/servo_frame_timer.sv
// Purpose : free-running frame counter that defines the servo PWM period.
// Latency : frame_start is registered, high on the cycle after the boundary (the count==0 cycle).
// Backpressure: none; runs every cycle.
//
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   cnt_next      value the counter takes at the next edge (0 when wrapping)
//   boundary      combinational, high on the last cycle of the frame (count == FRAME_CYCLES-1)
//   frame_start   registered one-cycle pulse on the first cycle of each frame
module servo_frame_timer #(
    parameter int unsigned FRAME_CYCLES = 1300000,
    parameter int unsigned COUNT_W      = 21
) (
    input  logic               clock,
    input  logic               reset,
    output logic [COUNT_W-1:0] cnt_next,
    output logic               boundary,
    output logic               frame_start
);

    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(FRAME_CYCLES - 1);

    logic [COUNT_W-1:0] frame_cnt;

    assign boundary = (frame_cnt == LAST);
    assign cnt_next = boundary ? '0 : frame_cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_cnt   <= cnt_next;
            frame_start <= boundary;
        end
    end

endmodule

// File: rtl/servo_pwm_driver.sv
// Purpose : fixed-period, glitch-free servo pulse generator; new widths only take effect at frame boundaries.
// Latency : accept to first pulse with the new width is 1..FRAME_CYCLES+1 cycles (longer with slew limiting).
// Backpressure: single pending slot; pos_ready drops the cycle after an accept and returns after the boundary transfer.
//
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   cmd           servo_pwm_driver_if.slave: pos / pos_valid / pos_ready (pos_ready registered)
//   enable        output enable, only looked at on the boundary cycle
//   pwm           registered servo pulse
//   frame_start   registered one-cycle pulse on the first cycle of each frame
//
// Build option: define SLEW_LIMIT_EN to limit the width change per frame to MAX_SLEW clocks;
// without it a pending width is applied in full at the next boundary and MAX_SLEW has no effect.
module servo_pwm_driver
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int unsigned MIN_PULSE    = DEF_MIN_PULSE,
    parameter int unsigned STEP         = DEF_STEP,
    parameter int unsigned COUNT_W      = DEF_COUNT_W,
    parameter int unsigned MAX_SLEW     = DEF_MAX_SLEW
) (
    input  logic                clock,
    input  logic                reset,
    servo_pwm_driver_if.slave   cmd,
    input  logic                enable,
    output logic                pwm,
    output logic                frame_start
);

`ifdef SLEW_LIMIT_EN
    localparam bit SLEW_ON = 1'b1;
`else
    localparam bit SLEW_ON = 1'b0;
`endif

    // With slewing off the limit is the full counter range, so the move below
    // always lands on the pending width in a single boundary.
    localparam logic [COUNT_W-1:0] SLEW_LIM     = SLEW_ON ? COUNT_W'(MAX_SLEW) : '1;
    localparam logic [COUNT_W-1:0] CENTER_WIDTH = COUNT_W'(MIN_PULSE + CENTER_POS * STEP);

    // Frame timing
    logic [COUNT_W-1:0] cnt_next;
    logic               boundary;

    servo_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES),
        .COUNT_W      (COUNT_W)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .cnt_next    (cnt_next),
        .boundary    (boundary),
        .frame_start (frame_start)
    );

    // State
    logic               pend_full;
    logic [COUNT_W-1:0] pend_width;
    logic [COUNT_W-1:0] active_width;
    logic               enable_q;
    logic               pos_ready_q;

    // Next-state
    logic               pend_full_n;
    logic [COUNT_W-1:0] pend_width_n;
    logic [COUNT_W-1:0] active_n;
    logic               enable_n;
    logic               pwm_n;

    logic               accept;
    logic [COUNT_W-1:0] target;
    logic               move_up;
    logic [COUNT_W-1:0] gap;

    assign cmd.pos_ready = pos_ready_q;
    assign accept        = cmd.pos_valid && pos_ready_q;
    assign target        = COUNT_W'(pos_to_width(cmd.pos, MIN_PULSE, STEP));

    always_comb begin
        pend_full_n  = pend_full;
        pend_width_n = pend_width;
        active_n     = active_width;
        enable_n     = enable_q;
        move_up      = 1'b0;
        gap          = '0;

        if (boundary) begin
            enable_n = enable;
            // The transfer looks at the pending slot as it was before this
            // cycle, so a command accepted on the boundary cycle waits a frame.
            if (pend_full) begin
                move_up = (pend_width > active_width);
                gap     = move_up ? (pend_width - active_width) : (active_width - pend_width);
                if (gap > SLEW_LIM) begin
                    active_n = move_up ? (active_width + SLEW_LIM) : (active_width - SLEW_LIM);
                end else begin
                    active_n = pend_width;
                end
                // Slot is only released once the target is actually reached.
                if (active_n == pend_width) begin
                    pend_full_n = 1'b0;
                end
            end
        end

        // pos_ready implies the slot was empty, so this never collides with a
        // transfer that is still holding the slot.
        if (accept) begin
            pend_full_n  = 1'b1;
            pend_width_n = target;
        end

        // Compare against next-cycle values so the pulse rises together with
        // frame_start and picks up the new width/enable on that same cycle.
        pwm_n = enable_n && (cnt_next < active_n);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_full    <= 1'b0;
            pend_width   <= '0;
            active_width <= CENTER_WIDTH;
            enable_q     <= 1'b0;
            pos_ready_q  <= 1'b1;
            pwm          <= 1'b0;
        end else begin
            pend_full    <= pend_full_n;
            pend_width   <= pend_width_n;
            active_width <= active_n;
            enable_q     <= enable_n;
            pos_ready_q  <= !pend_full_n;
            pwm          <= pwm_n;
        end
    end

endmodule
